// File: rtl/md_unit_e.sv
// Multiply/divide unit with HI/LO for the E stage: multi-cycle MULT/MULTU/DIV/DIVU
// with a fixed busy window, plus single-edge MTHI/MTLO writes while idle.
module md_unit_e #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbg_state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Result datapath works only from the operands latched at the accept edge.
  logic               signed_op, neg_a, neg_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   ua, ub, ub_safe, uq, ur, div_q, div_r;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    signed_op = ~op_q[0];
    ext_a     = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b     = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = ext_a * ext_b;

    // Sign-magnitude divide: truncation toward zero, remainder follows dividend.
    neg_a   = signed_op & a_q[WIDTH-1];
    neg_b   = signed_op & b_q[WIDTH-1];
    ua      = neg_a ? -a_q : a_q;
    ub      = neg_b ? -b_q : b_q;
    ub_safe = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    if (b_q == '0) begin
      div_q = '1;
      div_r = a_q;
    end else begin
      div_q = (neg_a ^ neg_b) ? -uq : uq;
      div_r = neg_a ? -ur : ur;
    end

    if (op_q[1]) begin
      res_hi = div_r;
      res_lo = div_q;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!md_op[2]) begin
            state_d = ST_RUN;
            op_d    = md_op[1:0];
            a_d     = a;
            b_d     = b;
            cnt_d   = md_op[1] ? DIV_LOAD : MUL_LOAD;
          end else if (md_op == 3'd4) begin
            hi_d = a;
          end else if (md_op == 3'd5) begin
            lo_d = a;
          end
        end
      end
      default: begin
        // Any start while running is dropped; the D stage is stalling it.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q[0];

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e: busy window length, HI/LO results, MTHI/MTLO,
// ignored starts, async reset mid-run and back-to-back issue.
module tb_md_unit_e;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  md_unit_e #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .md_op       (md_op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers: called at a negedge; present a request for one posedge, then
  // scramble operands so late changes on a/b would be visible in results.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts negedges with busy=1, starting at the current negedge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h state=%b expected 0 0 0 0", busy, hi, lo, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    logic [2:0]  ops [3];
    logic [31:0] avs [3];
    logic [31:0] bvs [3];
    logic [31:0] ehi [3];
    logic [31:0] elo [3];
    logic [31:0] old_hi, old_lo;
    int n;
    ops[0] = 3'd0; avs[0] = 32'hFFFF_FFFD; bvs[0] = 32'd5;        ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFF1;
    ops[1] = 3'd1; avs[1] = 32'hFFFF_FFFF; bvs[1] = 32'd2;        ehi[1] = 32'h0000_0001; elo[1] = 32'hFFFF_FFFE;
    ops[2] = 3'd0; avs[2] = 32'hFFFF_FFFF; bvs[2] = 32'hFFFF_FFFF; ehi[2] = 32'h0000_0000; elo[2] = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      old_hi = hi;
      old_lo = lo;
      issue(ops[i], avs[i], bvs[i]);
      checks++;
      if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
        errors++;
        $display("FAIL mult%0d_first_cycle busy=%b hi=%h lo=%h expected 1 %h %h", i, busy, hi, lo, old_hi, old_lo);
      end
      wait_idle(n);
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL mult%0d_busy_cycles got %0d expected 5", i, n);
      end
      checks++;
      if (hi !== ehi[i] || lo !== elo[i]) begin
        errors++;
        $display("FAIL mult%0d_result hi=%h lo=%h expected %h %h", i, hi, lo, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [5];
    logic [31:0] avs [5];
    logic [31:0] bvs [5];
    logic [31:0] ehi [5];
    logic [31:0] elo [5];
    int n;
    ops[0] = 3'd2; avs[0] = 32'hFFFF_FFF9; bvs[0] = 32'd2;         ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFFD;
    ops[1] = 3'd3; avs[1] = 32'd7;         bvs[1] = 32'd2;         ehi[1] = 32'd1;         elo[1] = 32'd3;
    ops[2] = 3'd2; avs[2] = 32'h1234_5678; bvs[2] = 32'd0;         ehi[2] = 32'h1234_5678; elo[2] = 32'hFFFF_FFFF;
    ops[3] = 3'd2; avs[3] = 32'h8000_0000; bvs[3] = 32'hFFFF_FFFF; ehi[3] = 32'h0;         elo[3] = 32'h8000_0000;
    ops[4] = 3'd2; avs[4] = 32'd7;         bvs[4] = 32'hFFFF_FFFE; ehi[4] = 32'd1;         elo[4] = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], avs[i], bvs[i]);
      wait_idle(n);
      checks++;
      if (n != 10) begin
        errors++;
        $display("FAIL div%0d_busy_cycles got %0d expected 10", i, n);
      end
      checks++;
      if (hi !== ehi[i] || lo !== elo[i]) begin
        errors++;
        $display("FAIL div%0d_result hi=%h lo=%h expected %h %h", i, hi, lo, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [31:0] old_hi;
    int n;
    old_hi = hi;
    issue(3'd0, 32'd6, 32'd7);          // busy cycle 1 now
    @(negedge clk);                     // busy cycle 2
    issue(3'd4, 32'h0000_00AA, 32'd0);  // mthi while busy
    checks++;
    if (hi !== old_hi || busy !== 1'b1) begin
      errors++;
      $display("FAIL mthi_while_busy hi=%h busy=%b expected %h 1", hi, busy, old_hi);
    end
    wait_idle(n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL busy_not_restarted remaining=%0d expected 3", n);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL mult_after_ignored hi=%h lo=%h expected 00000000 0000002a", hi, lo);
    end
    issue(3'd5, 32'h0000_0055, 32'd0);
    checks++;
    if (lo !== 32'h55 || hi !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_idle lo=%h hi=%h busy=%b expected 00000055 00000000 0", lo, hi, busy);
    end
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h55 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_idle hi=%h lo=%h busy=%b expected deadbeef 00000055 0", hi, lo, busy);
    end
    issue(3'd6, 32'h1111_1111, 32'd3);
    issue(3'd7, 32'h2222_2222, 32'd3);
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h55 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op hi=%h lo=%h busy=%b expected deadbeef 00000055 0", hi, lo, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) @(negedge clk);          // busy cycle 3
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL async_reset busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discards hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy);
    end
    issue(3'd0, 32'd3, 32'd4);
    wait_idle(n);
    checks++;
    if (n != 5 || hi !== 32'h0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL mult_after_reset cycles=%0d hi=%h lo=%h expected 5 00000000 0000000c", n, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    issue(3'd3, 32'd100, 32'd7);        // right after busy fell
    checks++;
    if (busy !== 1'b1 || hi !== 32'h1 || lo !== 32'h0) begin
      errors++;
      $display("FAIL b2b_first busy=%b hi=%h lo=%h expected 1 00000001 00000000", busy, hi, lo);
    end
    wait_idle(n);
    checks++;
    if (n != 10 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL b2b_second cycles=%0d hi=%h lo=%h expected 10 00000002 0000000e", n, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
